// File: rtl/neuron_mac_param.sv
// Parametrised fully-connected neuron: weight RAM, bias, pipelined signed MAC, requantise, activation.
// Build option NEURON_SAT_EN: saturate the requantised sum to DATA_W instead of wrapping it.
module neuron_mac_param #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FRAC_W     = 8,
   parameter int unsigned NUM_WEIGHT = 128,
   parameter int unsigned ID_W       = 8,
   parameter int unsigned LAYER_NO   = 1,
   parameter int unsigned NEURON_NO  = 0,
   parameter int unsigned ACT_MODE   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   cfg_layer,
   input  logic [ID_W-1:0]   cfg_neuron,
   input  logic              weight_valid,
   input  logic [DATA_W-1:0] weight_data,
   input  logic              bias_valid,
   input  logic [DATA_W-1:0] bias_data,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              busy,
   output logic              wload_err
);

   localparam int unsigned   AW       = $clog2(NUM_WEIGHT);
   localparam int unsigned   PROD_W   = 2 * DATA_W;
   localparam int unsigned   ACC_W    = PROD_W + AW;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WEIGHT - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ACCUM = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_BIAS  = 3'd3;
   localparam logic [2:0] ST_ACT   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   logic [2:0]               state_q, state_d;
   logic [AW-1:0]            wptr_q, wptr_d;
   logic [AW-1:0]            rptr_q, rptr_d;
   logic [DATA_W-1:0]        bias_q, bias_d;
   logic                     wload_err_q, wload_err_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0]        act_q;
   logic [DATA_W-1:0]        out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;

   logic                     s1_v_q, s1_last_q;
   logic                     s2_v_q, s2_last_q;
   logic                     acc_last_q;
   logic [DATA_W-1:0]        s1_x_q, s1_w_q;
   logic signed [PROD_W-1:0] prod_q;
   logic [DATA_W-1:0]        mem_q [NUM_WEIGHT];

   logic                     sel, busy_w, fire, last_in, w_we, wr_try;
   logic signed [PROD_W-1:0] x_ext, w_ext;
   logic signed [ACC_W-1:0]  prod_ext, bias_ext;
   logic [DATA_W-1:0]        q_red;
   logic [DATA_W-1:0]        act_val;

   assign sel      = (cfg_layer == ID_W'(LAYER_NO)) && (cfg_neuron == ID_W'(NEURON_NO));
   assign busy_w   = (state_q != ST_IDLE) || out_valid_q;
   assign in_ready = !rst && !out_valid_q && ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
   assign fire     = in_valid && in_ready;
   assign last_in  = (rptr_q == LAST_IDX);
   assign wr_try   = (weight_valid || bias_valid) && sel;
   assign w_we     = weight_valid && sel && !busy_w;

   assign x_ext    = {{DATA_W{s1_x_q[DATA_W-1]}}, s1_x_q};
   assign w_ext    = {{DATA_W{s1_w_q[DATA_W-1]}}, s1_w_q};
   assign prod_ext = {{AW{prod_q[PROD_W-1]}}, prod_q};
   // Bias is in the same Q format as inputs, so it lines up with products once shifted by FRAC_W.
   assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};

`ifdef NEURON_SAT_EN
   logic [ACC_W-FRAC_W-DATA_W:0] q_hi;
   logic                         unused_frac;

   assign q_hi        = acc_q[ACC_W-1:FRAC_W+DATA_W-1];
   assign unused_frac = ^acc_q[FRAC_W-1:0];

   always_comb begin
      if ((&q_hi) || !(|q_hi)) begin
         q_red = acc_q[FRAC_W +: DATA_W];
      end else if (q_hi[ACC_W-FRAC_W-DATA_W]) begin
         q_red = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         q_red = {1'b0, {(DATA_W-1){1'b1}}};
      end
   end
`else
   logic unused_acc;

   assign q_red      = acc_q[FRAC_W +: DATA_W];
   assign unused_acc = ^{acc_q[ACC_W-1:FRAC_W+DATA_W], acc_q[FRAC_W-1:0]};
`endif

   generate
      if (ACT_MODE == 0) begin : g_ident
         assign act_val = q_red;
      end else if (ACT_MODE == 1) begin : g_relu
         assign act_val = q_red[DATA_W-1] ? '0 : q_red;
      end else begin : g_hsig
         localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(1) << (FRAC_W - 1);
         localparam logic signed [DATA_W:0] ONE  = (DATA_W+1)'(1) << FRAC_W;
         logic signed [DATA_W:0] h;

         // One extra bit so the +0.5 offset can never wrap before the clamp.
         assign h       = ($signed({q_red[DATA_W-1], q_red}) >>> 2) + HALF;
         assign act_val = (h < 0)   ? '0 :
                          (h > ONE) ? ONE[DATA_W-1:0] : h[DATA_W-1:0];
      end
   endgenerate

   always_comb begin
      // NOTE: every variable gets a default first, so no path through this block can infer a latch.
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      bias_d      = bias_q;
      wload_err_d = wload_err_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;

      if (w_we) begin
         wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + AW'(1);
      end
      if (bias_valid && sel && !busy_w) begin
         bias_d = bias_data;
      end
      if (wr_try && busy_w) begin
         wload_err_d = 1'b1;
      end
      if (fire) begin
         rptr_d = last_in ? '0 : rptr_q + AW'(1);
      end
      if (s2_v_q) begin
         acc_d = acc_q + prod_ext;
      end

      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               acc_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (fire && last_in) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (acc_last_q) begin
               state_d = ST_BIAS;
            end
         end
         ST_BIAS: begin
            acc_d   = acc_q + bias_ext;
            state_d = ST_ACT;
         end
         ST_ACT: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            out_data_d  = act_q;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: the weight RAM and the MAC datapath have no reset; only the valid flags that qualify them do.
   always_ff @(posedge clk) begin
      if (w_we) begin
         mem_q[wptr_q] <= weight_data;
      end
      if (fire) begin
         s1_x_q <= in_data;
         s1_w_q <= mem_q[rptr_q];
      end
      prod_q <= x_ext * w_ext;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         rptr_q      <= '0;
         bias_q      <= '0;
         wload_err_q <= 1'b0;
         acc_q       <= '0;
         act_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         s1_v_q      <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_v_q      <= 1'b0;
         s2_last_q   <= 1'b0;
         acc_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         bias_q      <= bias_d;
         wload_err_q <= wload_err_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         s1_v_q      <= fire;
         s1_last_q   <= fire && last_in;
         s2_v_q      <= s1_v_q;
         s2_last_q   <= s1_last_q;
         acc_last_q  <= s2_v_q && s2_last_q;
         if (state_q == ST_ACT) begin
            act_q <= act_val;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_w;
   assign wload_err = wload_err_q;

endmodule
